// File: rtl/imem_ctrl_pkg.sv
// Shared definitions for the instruction-memory boot controller, the
// instruction memory and the CPU top.
package imem_ctrl_pkg;

  // Default instruction-memory geometry (4096 x 32).
  localparam int unsigned IMEM_ADDR_W = 12;
  localparam int unsigned IMEM_DATA_W = 32;
  localparam int unsigned RUN_CNT_W   = 32;

  // Controller state encoding; also exported on the state port.
  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StLoad = 2'b01,
    StRun  = 2'b10,
    StHalt = 2'b11
  } ctrl_state_e;

endpackage

// File: rtl/imem_boot_ctrl.sv
// Boot/run controller: streams a program image into instruction memory while
// holding the CPU in reset, releases it to run from PC 0, and parks it again
// on halt.
module imem_boot_ctrl
  import imem_ctrl_pkg::*;
#(
  parameter int unsigned ADDR_W = IMEM_ADDR_W,
  parameter int unsigned DATA_W = IMEM_DATA_W,
  parameter int unsigned CNT_W  = RUN_CNT_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld_start,
  input  logic [ADDR_W:0]   ld_len,
  input  logic              ld_valid,
  input  logic [DATA_W-1:0] ld_data,
  output logic              ld_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_waddr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              cpu_rst_n,
  input  logic              halt_req,
  output logic [1:0]        state,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [CNT_W-1:0]  cyc_cnt
);

  // Largest legal load: the whole memory.
  localparam logic [ADDR_W:0] MaxLen = {1'b1, {ADDR_W{1'b0}}};

  ctrl_state_e       state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  // Index of the final word of the current load (len - 1).
  logic [ADDR_W-1:0] last_q, last_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              err_q, err_d;
  logic              len_ok;

  assign len_ok = (ld_len != '0) && (ld_len <= MaxLen);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      ptr_q   <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Next-state logic plus the combinational memory write port.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    err_d     = err_q;
    ld_ready  = 1'b0;
    mem_we    = 1'b0;
    mem_waddr = '0;
    mem_wdata = '0;

    unique case (state_q)
      StIdle, StHalt: begin
        if (ld_start) begin
          if (len_ok) begin
            state_d = StLoad;
            ptr_d   = '0;
            // len = 2^ADDR_W has zero low bits, so this wraps to all-ones.
            last_d  = ld_len[ADDR_W-1:0] - ADDR_W'(1);
            cnt_d   = '0;
            err_d   = 1'b0;
          end else begin
            err_d = 1'b1;
          end
        end
      end
      StLoad: begin
        ld_ready  = 1'b1;
        mem_waddr = ptr_q;
        if (ld_valid) begin
          mem_we    = 1'b1;
          mem_wdata = ld_data;
          ptr_d     = ptr_q + ADDR_W'(1);
          if (ptr_q == last_q) begin
            state_d = StRun;
          end
        end
      end
      StRun: begin
        if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
        // halt has priority; ld_start is ignored while running.
        if (halt_req) begin
          state_d = StHalt;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Status outputs decode the registered state only.
  assign state     = state_q;
  assign busy      = (state_q == StLoad);
  assign done      = (state_q == StHalt);
  assign cpu_rst_n = (state_q == StRun);
  assign err       = err_q;
  assign cyc_cnt   = cnt_q;

endmodule

// File: tb/tb_imem_boot_ctrl.sv
// Scoreboard bench for imem_boot_ctrl: expected memory writes are queued by
// the stimulus process and retired by a monitor on every mem_we cycle.
module tb_imem_boot_ctrl;

  localparam int unsigned AW = 12;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          ld_start;
  logic [AW:0]   ld_len;
  logic          ld_valid;
  logic [DW-1:0] ld_data;
  logic          ld_ready;
  logic          mem_we;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          cpu_rst_n;
  logic          halt_req;
  logic [1:0]    state;
  logic          busy;
  logic          done;
  logic          err;
  logic [CW-1:0] cyc_cnt;

  int n_vec  = 0;
  int n_miss = 0;

  // Expected writes as {addr, data}.
  logic [AW+DW-1:0] exp_q[$];

  logic [31:0] prog[5] = '{32'h0020000F, 32'h0421000F, 32'h08400004,
                           32'h90610002, 32'h0FE30007};

  always #5 clk = ~clk;

  imem_boot_ctrl #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld_start  (ld_start),
    .ld_len    (ld_len),
    .ld_valid  (ld_valid),
    .ld_data   (ld_data),
    .ld_ready  (ld_ready),
    .mem_we    (mem_we),
    .mem_waddr (mem_waddr),
    .mem_wdata (mem_wdata),
    .cpu_rst_n (cpu_rst_n),
    .halt_req  (halt_req),
    .state     (state),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .cyc_cnt   (cyc_cnt)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_wr(input int addr, input logic [DW-1:0] data);
    exp_q.push_back({AW'(addr), data});
  endtask

  // Monitor: every write must be expected, in order, and only in LOAD.
  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      logic [AW+DW-1:0] e;
      chk("we_in_load", 64'(state), 64'(2'b01));
      if (exp_q.size() == 0) begin
        chk("unexpected_write", 64'({mem_waddr, mem_wdata}), 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        chk("waddr", 64'(mem_waddr), 64'(e[AW+DW-1:DW]));
        chk("wdata", 64'(mem_wdata), 64'(e[DW-1:0]));
      end
    end
  end

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_len = '0; ld_valid = 1'b0; ld_data = '0;
    halt_req = 1'b0;
    tick(); tick();
    rst = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("rst_state", 64'(state), 0);
    chk("rst_cpu_rst_n", 64'(cpu_rst_n), 0);
    chk("rst_mem_we", 64'(mem_we), 0);
    chk("rst_ld_ready", 64'(ld_ready), 0);
    chk("rst_waddr", 64'(mem_waddr), 0);
    chk("rst_wdata", 64'(mem_wdata), 0);
    chk("rst_busy_done_err", 64'({busy, done, err}), 0);
    chk("rst_cyc_cnt", 64'(cyc_cnt), 0);

    // 5-word back-to-back load.
    ld_start = 1'b1; ld_len = 13'd5;
    tick();
    ld_start = 1'b0;
    chk("load5_state", 64'(state), 1);
    chk("load5_ready", 64'(ld_ready), 1);
    chk("load5_busy", 64'(busy), 1);
    for (int i = 0; i < 5; i++) begin
      push_wr(i, prog[i]);
      ld_valid = 1'b1; ld_data = prog[i];
      tick();
    end
    ld_valid = 1'b0;
    chk("load5_run", 64'(state), 2);
    chk("load5_cpu_rst_n", 64'(cpu_rst_n), 1);
    chk("load5_cnt0", 64'(cyc_cnt), 0);
    chk("load5_ready_off", 64'(ld_ready), 0);

    // Ten RUN cycles, then halt with a competing ld_start.
    for (int i = 0; i < 9; i++) tick();
    chk("run_cnt9", 64'(cyc_cnt), 9);
    halt_req = 1'b1; ld_start = 1'b1; ld_len = 13'd2;
    tick();
    halt_req = 1'b0; ld_start = 1'b0;
    chk("halt_state", 64'(state), 3);
    chk("halt_done", 64'(done), 1);
    chk("halt_cnt10", 64'(cyc_cnt), 10);
    chk("halt_cpu_rst_n", 64'(cpu_rst_n), 0);
    chk("halt_err", 64'(err), 0);
    tick(); tick();
    chk("halt_cnt_frozen", 64'(cyc_cnt), 10);

    // Illegal lengths from HALT.
    ld_start = 1'b1; ld_len = 13'd0;
    tick();
    chk("len0_err", 64'(err), 1);
    chk("len0_state", 64'(state), 3);
    ld_len = 13'd4097;
    tick();
    ld_start = 1'b0;
    chk("len4097_err", 64'(err), 1);
    chk("len4097_state", 64'(state), 3);

    // Reload from HALT with 2 words; clears err and cyc_cnt.
    ld_start = 1'b1; ld_len = 13'd2;
    tick();
    ld_start = 1'b0;
    chk("reload_state", 64'(state), 1);
    chk("reload_err", 64'(err), 0);
    chk("reload_cnt", 64'(cyc_cnt), 0);
    for (int i = 0; i < 2; i++) begin
      push_wr(i, 32'hA5A5_0000 + 32'(i));
      ld_valid = 1'b1; ld_data = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    ld_valid = 1'b0;
    chk("reload_run", 64'(state), 2);
    chk("reload_run_cnt", 64'(cyc_cnt), 0);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;

    // 3-word load with bubbles; valid pattern 1,0,1,0,1.
    ld_start = 1'b1; ld_len = 13'd3;
    tick();
    ld_start = 1'b0;
    begin
      int w;
      w = 0;
      for (int i = 0; i < 5; i++) begin
        ld_valid = (i % 2 == 0);
        ld_data  = 32'hC000_0000 + 32'(i);
        if (ld_valid) begin
          push_wr(w, ld_data);
          w++;
        end
        #1;
        chk("bubble_we", 64'(mem_we), 64'(ld_valid));
        chk("bubble_ready", 64'(ld_ready), 1);
        tick();
      end
    end
    ld_valid = 1'b0;
    chk("bubble_run", 64'(state), 2);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;

    // Full-memory load: every address once, pointer wraps after the last write.
    ld_start = 1'b1; ld_len = 13'd4096;
    tick();
    ld_start = 1'b0;
    chk("full_state", 64'(state), 1);
    for (int i = 0; i < 4096; i++) begin
      push_wr(i, 32'(i) * 32'd3 + 32'd1);
      ld_valid = 1'b1; ld_data = 32'(i) * 32'd3 + 32'd1;
      tick();
    end
    ld_valid = 1'b0;
    chk("full_run", 64'(state), 2);
    chk("full_cpu_rst_n", 64'(cpu_rst_n), 1);
    halt_req = 1'b1;
    tick();
    halt_req = 1'b0;

    // Reset after the second word of a 5-word load.
    ld_start = 1'b1; ld_len = 13'd5;
    tick();
    ld_start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push_wr(i, prog[i]);
      ld_valid = 1'b1; ld_data = prog[i];
      tick();
    end
    ld_valid = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0; ld_valid = 1'b1; ld_data = prog[2];
    #1;
    chk("midrst_state", 64'(state), 0);
    chk("midrst_ready", 64'(ld_ready), 0);
    chk("midrst_waddr", 64'(mem_waddr), 0);
    chk("midrst_we", 64'(mem_we), 0);
    chk("midrst_cpu_rst_n", 64'(cpu_rst_n), 0);
    tick(); tick();
    ld_valid = 1'b0;
    chk("midrst_idle", 64'(state), 0);

    @(negedge clk);
    #1;
    chk("scoreboard_empty", 64'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
